// File: rtl/uart_recv.sv
// 8N1 UART receiver: double-synchronised line and mid-bit sampling.
// Outputs are a one-cycle valid or frame_err strobe per frame.
module uart_recv #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             sync_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             bit_done;

    // The start bit is sampled half a period in; every later bit a full period on.
    assign bit_done = (state_q == S_START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= rx;
            rx_s_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s_q) state_d = S_START;
            S_START: if (bit_done) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:  if (bit_done && idx_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (bit_done) state_d = rx_s_q ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (state_d != state_q || bit_done || state_q == S_IDLE || state_q == S_BREAK) begin
            cnt_d = '0;
        end
        case (state_q)
            S_START: if (bit_done) idx_d = '0;
            S_DATA: begin
                if (bit_done) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv: table of clean frames plus hand-written
// glitch, framing-error, reset and held-low sequences, then a random byte stream.
`timescale 1ns/1ps
module tb_uart_recv;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    uart_recv #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int vld_cnt = 0, ferr_cnt = 0, overlap = 0, dbl = 0, last_vld_cyc = 0;
    bit pv = 0, pf = 0;
    int t_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts pulses and records protocol violations.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vld_cnt++;
            last_vld_cyc = cyc;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (valid === 1'b1 && frame_err === 1'b1) overlap++;
        if ((valid === 1'b1 && pv) || (frame_err === 1'b1 && pf)) dbl++;
        pv = (valid === 1'b1);
        pf = (frame_err === 1'b1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
        rx = 1'b0;
        t_fall = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] b;
        int         gap;
        logic [7:0] exp_data;
        int         exp_space;
    } vec_t;

    vec_t vt[6];

    initial begin
        int v0, f0, pc, wait_n, busy_n;
        logic [7:0] rb;

        vt[0] = '{8'hA5, 20, 8'hA5, 0};
        vt[1] = '{8'h00, 5,  8'h00, 0};
        vt[2] = '{8'hFF, 0,  8'hFF, 10 * CPB};
        vt[3] = '{8'h01, 3,  8'h01, 0};
        vt[4] = '{8'h80, 0,  8'h80, 10 * CPB};
        vt[5] = '{8'hC3, 7,  8'hC3, 0};

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Clean frames, including back-to-back with no idle gap
        for (int i = 0; i < 6; i++) begin
            v0 = vld_cnt;
            f0 = ferr_cnt;
            pc = last_vld_cyc;
            send_frame(vt[i].b, 1'b1, vt[i].gap);
            check($sformatf("tbl%0d_valid_cnt", i), vld_cnt - v0, 1);
            check($sformatf("tbl%0d_ferr_cnt", i), ferr_cnt - f0, 0);
            check($sformatf("tbl%0d_data", i), int'(data), int'(vt[i].exp_data));
            check($sformatf("tbl%0d_busy", i), int'(busy), 0);
            check_range($sformatf("tbl%0d_latency", i), last_vld_cyc - t_fall,
                        1 + CPB / 2 + 9 * CPB, 3 + CPB / 2 + 9 * CPB);
            if (vt[i].exp_space != 0)
                check($sformatf("tbl%0d_spacing", i), last_vld_cyc - pc, vt[i].exp_space);
        end

        // Short low glitch is rejected
        v0 = vld_cnt;
        f0 = ferr_cnt;
        busy_n = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) rx = 1'b1;
            if (busy === 1'b1) busy_n++;
        end
        check_range("glitch_busy_cycles", busy_n, 1, 8);
        check("glitch_valid", vld_cnt - v0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy_end", int'(busy), 0);

        // Stop bit low, line held low afterwards
        v0 = vld_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 4);
        repeat (50) @(negedge clk);
        check("ferr_pulse", ferr_cnt - f0, 1);
        check("ferr_no_valid", vld_cnt - v0, 0);
        check("ferr_data_kept", int'(data), 8'hC3);
        check("ferr_busy_held", int'(busy), 1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_busy_release", int'(busy), 0);

        // Reset during data bit 4 of 0x12
        v0 = vld_cnt;
        rb = 8'h12;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx = rb[i];
            repeat ((i == 4) ? CPB / 2 : CPB) @(negedge clk);
        end
        check("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data", int'(data), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_ferr", int'(frame_err), 0);
        check("midrst_busy", int'(busy), 0);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("midrst_no_valid", vld_cnt - v0, 0);
        send_frame(8'h3C, 1'b1, 0);
        check("midrst_next_valid", vld_cnt - v0, 1);
        check("midrst_next_data", int'(data), 8'h3C);

        // Line held low across reset release
        rx  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0 = vld_cnt;
        f0 = ferr_cnt;
        wait_n = 0;
        while (ferr_cnt == f0 && wait_n < 400) begin
            @(negedge clk);
            wait_n++;
        end
        check("heldlow_ferr", ferr_cnt - f0, 1);
        repeat (20) @(negedge clk);
        check("heldlow_no_valid", vld_cnt - v0, 0);
        check("heldlow_data", int'(data), 0);
        check("heldlow_busy", int'(busy), 1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("heldlow_release", int'(busy), 0);

        // Random byte stream at matching bit period
        f0 = ferr_cnt;
        for (int i = 0; i < 20; i++) begin
            rb = 8'($urandom_range(0, 255));
            v0 = vld_cnt;
            send_frame(rb, 1'b1, i % 3);
            check($sformatf("loop%0d_valid", i), vld_cnt - v0, 1);
            check($sformatf("loop%0d_data", i), int'(data), int'(rb));
        end
        check("loop_no_ferr", ferr_cnt - f0, 0);

        check("strobe_overlap", overlap, 0);
        check("strobe_width", dbl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
